ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//  Timing front-end for main memory, directly downstream of the coherence/arbitration memory controller.
//  Consumes ramREN/ramWEN/ramaddr/ramstore; produces ramstate/ramload with fixed, parameterised access latency.
//  Owns the word-addressed backing store through sub-module ram_store.
//  One request is in flight at a time; a held request completes once, then restarts as a new access.
// PARAMETERS
//  LAT      2     BUSY cycles before ACCESS; legal range 1..15
//  AWIDTH   16    byte-address bits decoded; DEPTH = 2**(AWIDTH-2) words
// PORTS
//  CLK        in   1   clock; all state updates on posedge
//  nRST       in   1   reset; asynchronous, active-high (asserted = 1)
//  ramREN     in   1   read request, level, held until ACCESS
//  ramWEN     in   1   write request, level, held until ACCESS
//  ramaddr    in   32  byte address (word_t)
//  ramstore   in   32  write data (word_t)
//  ramstate   out  2   ramstate_t: FREE / BUSY / ACCESS / ERROR
//  ramload    out  32  read data; valid only in ACCESS cycle of a read
//  rd_count   out  32  reads completed      (RAM_STATS_EN only)
//  wr_count   out  32  writes completed     (RAM_STATS_EN only)
//  err_count  out  32  ERROR cycles         (RAM_STATS_EN only)
// BEHAVIOUR
//  - Reset: FSM IDLE, cnt=0, latched req cleared, ramload=0, counters 0; ramstate=FREE while reset asserted.
//  - FSM (ramctl_state_t): IDLE, WAIT, DONE.
//  - req = ramREN|ramWEN. bad = (ramREN&ramWEN) | ramaddr[1:0]!=0 | ramaddr[31:AWIDTH]!=0.
//  - IDLE: !req -> ramstate FREE. bad -> ramstate ERROR this cycle, stay IDLE, no write.
//    Else ramstate BUSY, latch {REN,WEN,addr,store}, cnt<=LAT-1, -> WAIT (LAT=1: cnt=0).
//  - WAIT: ramstate BUSY.
//    Inputs differ from latch -> relatch, cnt<=LAT-1 (restart). bad -> ERROR, -> IDLE.
//    !req -> IDLE (abort, no write). cnt!=0 -> cnt--.
//    cnt==0 -> -> DONE; read issued to ram_store, data registered for the next cycle.
//  - DONE: ramstate ACCESS for exactly one cycle.
//    Read: ramload = store[addr>>2].
//    Write: store[addr>>2] <= ramstore at the closing edge. Next state IDLE.
//  - Latency: request first seen cycle 0; BUSY cycles 0..LAT; ACCESS in cycle LAT+1.
//  - Back-to-back: request held past ACCESS (e.g. second burst word, new addr) starts a fresh access the next cycle.
//  - ramload holds its last value outside ACCESS; a write never updates ramload.
//  - Input change in the DONE cycle is ignored: the access completes on the latched request.
//  - Reset mid-access aborts it; no partial write; store contents are not cleared by reset.
//  - Word index wraps nothing: out-of-range addresses are ERROR, never aliased.
// CONFIGURATION
//  - RAM_STATS_EN defined: rd_count/wr_count/err_count ports exist.
//    Each ACCESS read/write increments its counter; each ERROR cycle increments err_count; 32-bit wrap.
//  - RAM_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - cpu_types_pkg: existing word_t, ramstate_t; add ramctl_state_t {IDLE,WAIT,DONE} and RAM_LAT_DEFAULT=2.
//  - Sub-module ram_store: DEPTH x 32 array, 1 sync write port, 1 registered read port.
//  - All FSM/counter logic in ram_access_ctrl.
// TESTING
//  1. LAT=2: write 0xDEADBEEF @0x40, then read 0x40.
//     -> BUSY cycles 0-2, ACCESS cycle 3 each; ramload=0xDEADBEEF.
//  2. ramREN held for 4 consecutive addresses 0x0,0x4,0x8,0xC.
//     -> 4 ACCESS pulses 4 cycles apart; data per preloaded words.
//  3. In WAIT: addr changes 0x40->0x80 at cycle 1.
//     -> counter restarts, ACCESS at cycle 4, data from 0x80.
//  4. Error cases: REN&WEN=1, addr 0x42, addr 0x10000 (AWIDTH=16).
//     -> ERROR same cycle; no store change; err_count+1 each (stats build).
//  5. Reset during WAIT of write 0x55 @0x20.
//     -> ramstate FREE, ramload=0; mem[0x20] keeps its old value.
//  6. Build without RAM_STATS_EN; rerun 1-3 -> identical ramstate/ramload trace.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: word and RAM handshake encodings, RAM controller FSM states
// and the latched-request payload.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [1:0] ramctl_state_t;
  localparam ramctl_state_t IDLE = 2'd0;
  localparam ramctl_state_t WAIT = 2'd1;
  localparam ramctl_state_t DONE = 2'd2;

  localparam int unsigned RAM_LAT_DEFAULT = 2;
  localparam int unsigned RAM_CNT_W       = 4;

  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;
  } ram_req_t;

endpackage

// File: rtl/ram_access_ctrl_store.sv
// Word-addressed backing store: one synchronous write port, one registered read port.
// Contents survive reset; only the read register is cleared.
module ram_store
  import cpu_types_pkg::*;
#(
  parameter int unsigned IW = 14
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] idx,
  input  word_t         wdata,
  output word_t         rdata
);

  localparam int unsigned DEPTH = 2 ** IW;

  word_t mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[idx] <= wdata;
  end

  // Read register doubles as the visible load value, so it only moves on a read.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST)    rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Fixed-latency timing front-end for main memory; one request in flight at a time.
// Optional RAM_STATS_EN adds read/write/error counters.
module ram_access_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT    = RAM_LAT_DEFAULT,
  parameter int unsigned AWIDTH = 16
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output ramstate_t ramstate,
  output word_t     ramload
`ifdef RAM_STATS_EN
  ,
  output word_t     rd_count,
  output word_t     wr_count,
  output word_t     err_count
`endif
);

  localparam int unsigned IW = AWIDTH - 2;
  localparam int unsigned CW = RAM_CNT_W;

  ramctl_state_t  state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  ram_req_t       req_q, req_d, req_in;
  logic           req, bad, re, we;

  assign req_in = '{ren: ramREN, wen: ramWEN, addr: ramaddr, store: ramstore};
  assign req    = ramREN | ramWEN;
  assign bad    = req & ((ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) |
                         ((ramaddr >> AWIDTH) != 32'd0));
  assign we     = (state_q == DONE) & req_q.wen;

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Next state, counter and handshake; WAIT restarts on any input change.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    re       = 1'b0;
    ramstate = FREE;
    case (state_q)
      IDLE: begin
        if (bad) begin
          ramstate = ERROR;
        end else if (req) begin
          ramstate = BUSY;
          req_d    = req_in;
          cnt_d    = CW'(LAT - 1);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        ramstate = BUSY;
        if (bad) begin
          ramstate = ERROR;
          state_d  = IDLE;
        end else if (!req) begin
          state_d = IDLE;
        end else if (req_in != req_q) begin
          req_d = req_in;
          cnt_d = CW'(LAT - 1);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          re      = req_q.ren;
          state_d = DONE;
        end
      end
      DONE: begin
        ramstate = ACCESS;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (nRST) ramstate = FREE;
  end

  ram_store #(.IW(IW)) u_store (
    .CLK   (CLK),
    .nRST  (nRST),
    .we    (we),
    .re    (re),
    .idx   (req_q.addr[AWIDTH-1:2]),
    .wdata (req_q.store),
    .rdata (ramload)
  );

`ifdef RAM_STATS_EN
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      rd_count  <= '0;
      wr_count  <= '0;
      err_count <= '0;
    end else begin
      if (state_q == DONE && req_q.ren) rd_count  <= rd_count + 32'd1;
      if (we)                           wr_count  <= wr_count + 32'd1;
      if (ramstate == ERROR)            err_count <= err_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Randomized scoreboard bench for ram_access_ctrl: the driver predicts the per-cycle
// ramstate trace and each ACCESS/ERROR response from a word-level memory model.
module tb_ram_access_ctrl;
  import cpu_types_pkg::*;

  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = 16;
  localparam int NP = 19;

  logic      CLK = 1'b0;
  logic      nRST = 1'b1;
  logic      ramREN = 1'b0;
  logic      ramWEN = 1'b0;
  word_t     ramaddr = '0;
  word_t     ramstore = '0;
  ramstate_t ramstate;
  word_t     ramload;
`ifdef RAM_STATS_EN
  word_t     rd_count, wr_count, err_count;
`endif

  ram_access_ctrl #(.LAT(LAT), .AWIDTH(AW)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramstate (ramstate),
    .ramload  (ramload)
`ifdef RAM_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count),
    .err_count(err_count)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit    is_err;
    word_t data;
    int    at;
  } exp_t;

  exp_t      sbq[$];
  ramstate_t exp_st[int];
  word_t     mem_m[int];
  word_t     pool[NP];
  word_t     last_load = '0;
  bit        pend_done = 1'b0;
  int        checks = 0;
  int        passes = 0;
  int        n_rd = 0, n_wr = 0, n_err = 0;

  task automatic chk(input string name, input word_t act, input word_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: whole ramstate trace plus scoreboard pop on every ACCESS/ERROR.
  ramstate_t mon_e;
  exp_t      mon_x;
  always @(negedge CLK) begin
    if (!nRST) begin
      mon_e = exp_st.exists(cyc) ? exp_st[cyc] : FREE;
      chk("ramstate", 32'(ramstate), 32'(mon_e));
      if (ramstate == ACCESS || ramstate == ERROR) begin
        if (sbq.size() == 0) begin
          chk("unexpected_response", 32'(ramstate), 32'(FREE));
        end else begin
          mon_x = sbq.pop_front();
          chk("resp_kind", 32'(ramstate == ERROR), 32'(mon_x.is_err));
          chk("resp_cycle", 32'(cyc), 32'(mon_x.at));
          chk("ramload", ramload, mon_x.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit ren, input bit wen, input word_t a, input word_t d);
    ramREN   = ren;
    ramWEN   = wen;
    ramaddr  = a;
    ramstore = d;
  endtask

  task automatic mark(input int from, input int to, input ramstate_t st);
    for (int c = from; c <= to; c++) exp_st[c] = st;
  endtask

  task automatic push_resp(input bit is_err, input int at);
    exp_t e;
    e.is_err = is_err;
    e.data   = last_load;
    e.at     = at;
    sbq.push_back(e);
  endtask

  // One full access; inputs are left driven through the ACCESS cycle.
  task automatic access(input bit ren, input word_t a, input word_t d);
    int s;
    s = pend_done ? cyc + 1 : cyc;
    mark(s, s + int'(LAT), BUSY);
    exp_st[s + int'(LAT) + 1] = ACCESS;
    if (ren) begin
      last_load = mem_m[a];
      n_rd++;
    end else begin
      mem_m[a] = d;
      n_wr++;
    end
    push_resp(1'b0, s + int'(LAT) + 1);
    drive(ren, !ren, a, d);
    if (pend_done) step();
    repeat (LAT + 1) step();
    pend_done = 1'b1;
  endtask

  // Address/data change one cycle into WAIT: the count restarts on the new request.
  task automatic change(input bit ren, input word_t a1, input word_t a2,
                        input word_t d1, input word_t d2);
    int s;
    s = pend_done ? cyc + 1 : cyc;
    mark(s, s + int'(LAT) + 1, BUSY);
    exp_st[s + int'(LAT) + 2] = ACCESS;
    if (ren) begin
      last_load = mem_m[a2];
      n_rd++;
    end else begin
      mem_m[a2] = d2;
      n_wr++;
    end
    push_resp(1'b0, s + int'(LAT) + 2);
    drive(ren, !ren, a1, d1);
    if (pend_done) step();
    step();
    drive(ren, !ren, a2, d2);
    repeat (LAT + 1) step();
    pend_done = 1'b1;
  endtask

  task automatic abort(input bit ren, input word_t a, input word_t d, input int k);
    int s;
    s = pend_done ? cyc + 1 : cyc;
    mark(s, s + k, BUSY);
    drive(ren, !ren, a, d);
    if (pend_done) step();
    repeat (k) step();
    drive(1'b0, 1'b0, '0, '0);
    step();
    pend_done = 1'b0;
  endtask

  task automatic bad_idle(input bit ren, input bit wen, input word_t a, input word_t d);
    int s;
    s = pend_done ? cyc + 1 : cyc;
    exp_st[s] = ERROR;
    push_resp(1'b1, s);
    n_err++;
    drive(ren, wen, a, d);
    if (pend_done) step();
    step();
    drive(1'b0, 1'b0, '0, '0);
    pend_done = 1'b0;
  endtask

  task automatic bad_wait(input bit ren, input word_t a, input word_t d,
                          input bit bren, input bit bwen, input word_t ba, input int k);
    int s;
    s = pend_done ? cyc + 1 : cyc;
    mark(s, s + k - 1, BUSY);
    exp_st[s + k] = ERROR;
    push_resp(1'b1, s + k);
    n_err++;
    drive(ren, !ren, a, d);
    if (pend_done) step();
    repeat (k) step();
    drive(bren, bwen, ba, d);
    step();
    drive(1'b0, 1'b0, '0, '0);
    pend_done = 1'b0;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, '0, '0);
    repeat (n) step();
    pend_done = 1'b0;
  endtask

  task automatic make_bad(input int kind, input word_t a,
                          output bit ren, output bit wen, output word_t ba);
    ren = 1'b1;
    wen = 1'b1;
    ba  = a;
    if (kind == 1) begin
      ren = 1'($urandom_range(0, 1));
      wen = !ren;
      ba  = a | 32'($urandom_range(1, 3));
    end else if (kind == 2) begin
      ren = 1'($urandom_range(0, 1));
      wen = !ren;
      ba  = a | (32'd1 << $urandom_range(AW, 31));
    end
  endtask

  // Reset in WAIT of a write: aborts it, clears ramload, leaves the store intact.
  task automatic reset_mid_write(input word_t a, input word_t d);
    int s;
    idle(1);
    s = cyc;
    exp_st[s] = BUSY;
    drive(1'b0, 1'b1, a, d);
    step();
    nRST = 1'b1;
    #1;
    chk("reset_ramstate", 32'(ramstate), 32'(FREE));
    chk("reset_ramload", ramload, 32'h0);
    drive(1'b0, 1'b0, '0, '0);
    step();
    step();
    nRST = 1'b0;
    last_load = '0;
    n_rd = 0;
    n_wr = 0;
    n_err = 0;
    pend_done = 1'b0;
    #1;
    chk("post_reset_ramload", ramload, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int    op, k, bk;
    word_t a, a2, d, ba;
    bit    r, bren, bwen;

    for (int i = 0; i < 16; i++) pool[i] = 32'(4 * i);
    pool[16] = 32'h40;
    pool[17] = 32'h80;
    pool[18] = 32'hFFFC;

    repeat (2) step();
    chk("reset_ramstate", 32'(ramstate), 32'(FREE));
    chk("reset_ramload", ramload, 32'h0);
    nRST = 1'b0;
    step();

    for (int i = 0; i < NP; i++) access(1'b0, pool[i], $urandom);
    idle(2);

    access(1'b0, 32'h40, 32'hDEADBEEF);
    access(1'b1, 32'h40, 32'h0);
    idle(1);

    for (int i = 0; i < 4; i++) access(1'b1, 32'(4 * i), 32'h0);
    idle(1);

    change(1'b1, 32'h40, 32'h80, 32'h0, 32'h0);
    idle(1);

    bad_idle(1'b1, 1'b1, 32'h40, 32'h12345678);
    bad_idle(1'b0, 1'b1, 32'h42, 32'h12345678);
    bad_idle(1'b0, 1'b1, 32'h10000, 32'h12345678);
    access(1'b1, 32'h40, 32'h0);
    idle(1);

    reset_mid_write(32'h20, 32'h55);
    access(1'b1, 32'h20, 32'h0);

    access(1'b1, 32'hFFFC, 32'h0);
    access(1'b1, 32'hFFFC, 32'h0);
    idle(1);

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 9);
      a  = pool[$urandom_range(0, NP - 1)];
      d  = $urandom;
      r  = 1'($urandom_range(0, 1));
      k  = $urandom_range(1, LAT);
      bk = $urandom_range(0, 2);
      case (op)
        0, 1, 2, 3, 4: access(r, a, d);
        5: idle($urandom_range(1, 3));
        6: begin
          a2 = a;
          while (a2 == a) a2 = pool[$urandom_range(0, NP - 1)];
          change(r, a, a2, d, $urandom);
        end
        7: abort(r, a, d, k);
        8: begin
          make_bad(bk, a, bren, bwen, ba);
          bad_idle(bren, bwen, ba, d);
        end
        default: begin
          make_bad(bk, a, bren, bwen, ba);
          bad_wait(r, a, d, bren, bwen, ba, k);
        end
      endcase
    end

    for (int i = 0; i < NP; i++) access(1'b1, pool[i], 32'h0);
    idle(4);

    chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
`ifdef RAM_STATS_EN
    chk("rd_count", rd_count, 32'(n_rd));
    chk("wr_count", wr_count, 32'(n_wr));
    chk("err_count", err_count, 32'(n_err));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
